// File: rtl/spi_reg_writer.sv
// SPI initiator (mode 0, write-only) that sends one 24-bit frame {4'h0, addr, data}
// per accepted register-write request. All SPI and handshake outputs are registered.
//
// Handshake: a request is taken on any rising clk_in edge where data_valid_in=1 and
// ready_out=1. addr_in/data_in are sampled on that edge only. Requests seen while
// ready_out=0 are dropped; nothing is queued.
module spi_reg_writer #(
  parameter int CLK_DIV = 4  // clk_in cycles per SCLK half-period, legal 2..255
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [3:0]  addr_in,
  input  logic [15:0] data_in,
  input  logic        data_valid_in,
  output logic        ready_out,
  output logic        done_out,
  output logic        spi_cs_out,
  output logic        spi_mosi_out,
  output logic        spi_sclk_out
);

  typedef enum logic [2:0] {
    IDLE,
    SCK_LOW,
    SCK_HIGH,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  div_cnt;
  logic [7:0]  div_nx;
  logic [4:0]  bit_cnt;
  logic [4:0]  bit_nx;
  logic [23:0] shift;
  logic [23:0] shift_nx;

  logic cs_nx;
  logic sclk_nx;
  logic mosi_nx;
  logic done_nx;
  logic ready_nx;

  logic div_end;
  logic accept;

  assign div_end = (div_cnt == DIV_LAST);
  assign accept  = data_valid_in && ready_out;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state        <= IDLE;
      div_cnt      <= 8'd0;
      bit_cnt      <= 5'd0;
      shift        <= 24'd0;
      spi_cs_out   <= 1'b1;
      spi_sclk_out <= 1'b0;
      spi_mosi_out <= 1'b0;
      done_out     <= 1'b0;
      ready_out    <= 1'b1;
    end else begin
      state        <= state_nx;
      div_cnt      <= div_nx;
      bit_cnt      <= bit_nx;
      shift        <= shift_nx;
      spi_cs_out   <= cs_nx;
      spi_sclk_out <= sclk_nx;
      spi_mosi_out <= mosi_nx;
      done_out     <= done_nx;
      ready_out    <= ready_nx;
    end
  end

  always_comb begin
    state_nx = state;
    div_nx   = div_cnt + 8'd1;
    bit_nx   = bit_cnt;
    shift_nx = shift;

    case (state)
      IDLE: begin
        div_nx = 8'd0;
        if (accept) begin
          shift_nx = {4'b0000, addr_in, data_in};
          bit_nx   = 5'd23;
          state_nx = SCK_LOW;
        end
      end
      SCK_LOW: begin
        if (div_end) begin
          div_nx   = 8'd0;
          state_nx = SCK_HIGH;
        end
      end
      SCK_HIGH: begin
        if (div_end) begin
          div_nx = 8'd0;
          if (bit_cnt == 5'd0) begin
            state_nx = HOLD;
          end else begin
            // Shifting on the falling-edge cycle keeps MOSI stable for the whole high phase.
            shift_nx = {shift[22:0], 1'b0};
            bit_nx   = bit_cnt - 5'd1;
            state_nx = SCK_LOW;
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          div_nx   = 8'd0;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (div_end) begin
          div_nx   = 8'd0;
          state_nx = IDLE;
        end
      end
      default: begin
        div_nx   = 8'd0;
        state_nx = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so each one lands in a flop.
    cs_nx    = !(state_nx inside {SCK_LOW, SCK_HIGH, HOLD});
    sclk_nx  = (state_nx == SCK_HIGH);
    mosi_nx  = (state_nx == SCK_LOW || state_nx == SCK_HIGH) ? shift_nx[23] : 1'b0;
    done_nx  = (state == HOLD) && (state_nx == GAP);
    ready_nx = (state_nx == IDLE);
  end

  sclk_only_in_frame: assert property (@(posedge clk_in) disable iff (reset_in)
    spi_sclk_out |-> !spi_cs_out);
  done_with_cs_high: assert property (@(posedge clk_in) disable iff (reset_in)
    done_out |-> spi_cs_out);
  ready_only_when_cs_high: assert property (@(posedge clk_in) disable iff (reset_in)
    ready_out |-> spi_cs_out);

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: one DUT at CLK_DIV=4, one at CLK_DIV=2,
// a bench-side frame decoder, and immediate-assert checks against hand-computed frames.
module tb_spi_reg_writer;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [3:0]  addr_in = 4'd0;
  logic [15:0] data_in = 16'd0;
  logic        data_valid_in = 1'b0;
  logic        data_valid2 = 1'b0;

  logic ready0, done0, cs0, mosi0, sclk0;
  logic ready2, done2, cs2, mosi2, sclk2;

  logic sel = 1'b0;
  logic s_cs, s_mosi, s_sclk, s_done, s_ready;

  int total = 0;
  int bad = 0;

  logic [23:0] cap_frame;
  int cap_edges, cap_low, cap_hp_bad, cap_done_cnt, cap_pre_high, cap_pre_ready;
  logic cap_done_end, cap_timeout;

  always #5 clk_in = ~clk_in;

  spi_reg_writer #(.CLK_DIV(4)) dut0 (
    .clk_in(clk_in), .reset_in(reset_in), .addr_in(addr_in), .data_in(data_in),
    .data_valid_in(data_valid_in), .ready_out(ready0), .done_out(done0),
    .spi_cs_out(cs0), .spi_mosi_out(mosi0), .spi_sclk_out(sclk0)
  );

  spi_reg_writer #(.CLK_DIV(2)) dut2 (
    .clk_in(clk_in), .reset_in(reset_in), .addr_in(addr_in), .data_in(data_in),
    .data_valid_in(data_valid2), .ready_out(ready2), .done_out(done2),
    .spi_cs_out(cs2), .spi_mosi_out(mosi2), .spi_sclk_out(sclk2)
  );

  assign s_cs    = sel ? cs2    : cs0;
  assign s_mosi  = sel ? mosi2  : mosi0;
  assign s_sclk  = sel ? sclk2  : sclk0;
  assign s_done  = sel ? done2  : done0;
  assign s_ready = sel ? ready2 : ready0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; samples the selected DUT every negedge until its frame ends.
  task automatic capture(input int div, input int inject_at, input bit drop_valid);
    int n;
    int lo_run;
    int hi_run;
    int inj;
    logic prev_sclk;
    logic prev_mosi;
    cap_frame = 24'd0; cap_edges = 0; cap_low = 0; cap_hp_bad = 0;
    cap_done_cnt = 0; cap_done_end = 1'b0; cap_pre_high = 0; cap_pre_ready = 0;
    cap_timeout = 1'b0;
    n = 0; lo_run = 0; hi_run = 0; inj = 0; prev_sclk = 1'b0; prev_mosi = 1'b0;
    while (s_cs === 1'b1 && n < 1000) begin
      cap_pre_high++;
      if (s_ready) cap_pre_ready++;
      if (s_done) cap_done_cnt++;
      @(negedge clk_in);
      n++;
    end
    if (s_cs !== 1'b0) begin
      cap_timeout = 1'b1;
      return;
    end
    n = 0;
    while (s_cs === 1'b0 && n < 60 * div + 20) begin
      cap_low++;
      if (s_done) cap_done_cnt++;
      if (s_sclk && !prev_sclk) begin
        if (lo_run != div) cap_hp_bad++;
        lo_run = 0;
        cap_edges++;
        cap_frame = {cap_frame[22:0], s_mosi};
      end
      if (!s_sclk && prev_sclk) begin
        if (hi_run != div) cap_hp_bad++;
        hi_run = 0;
      end
      if (s_sclk && prev_sclk && s_mosi !== prev_mosi) cap_hp_bad++;
      if (s_sclk) hi_run++;
      else lo_run++;
      prev_sclk = s_sclk;
      prev_mosi = s_mosi;
      if (drop_valid && n == 0) data_valid_in = 1'b0;
      if (inj == 1) begin
        data_valid_in = 1'b0;
        inj = 2;
      end else if (inj == 0 && cap_edges == inject_at) begin
        addr_in = 4'h1;
        data_in = 16'h1234;
        data_valid_in = 1'b1;
        inj = 1;
      end
      @(negedge clk_in);
      n++;
    end
    if (s_cs !== 1'b1) begin
      cap_timeout = 1'b1;
      return;
    end
    cap_done_end = s_done;
    if (s_done) cap_done_cnt++;
    @(negedge clk_in);
  endtask

  initial begin
    int n;
    int edges;
    int cnt_a;
    int cnt_b;
    logic prev;

    // Reset state
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_cs", cs0, 1'b1);
    chk("rst_sclk", sclk0, 1'b0);
    chk("rst_mosi", mosi0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_ready", ready0, 1'b1);
    chk("rst_ready_div2", ready2, 1'b1);
    reset_in = 1'b0;
    @(negedge clk_in);

    // Basic frame addr=3 data=A55A
    addr_in = 4'h3; data_in = 16'hA55A; data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    chk("t1_ready_low", ready0, 1'b0);
    capture(4, -1, 1'b0);
    chk("t1_timeout", cap_timeout, 1'b0);
    chk("t1_frame", cap_frame, 24'h03A55A);
    chk("t1_edges", cap_edges, 24);
    chk("t1_cs_low", cap_low, 196);
    chk("t1_halfper", cap_hp_bad, 0);
    chk("t1_done_end", cap_done_end, 1'b1);
    chk("t1_done_cnt", cap_done_cnt, 1);

    // Back-to-back with valid held high
    repeat (10) @(negedge clk_in);
    addr_in = 4'hF; data_in = 16'hFFFF; data_valid_in = 1'b1;
    @(negedge clk_in);
    addr_in = 4'h0; data_in = 16'h0001;
    capture(4, -1, 1'b0);
    chk("b2b_f1_timeout", cap_timeout, 1'b0);
    chk("b2b_f1_frame", cap_frame, 24'h0FFFFF);
    capture(4, -1, 1'b1);
    chk("b2b_f2_timeout", cap_timeout, 1'b0);
    chk("b2b_gap_cs_high", cap_pre_high + 1, 5);
    chk("b2b_gap_ready", cap_pre_ready, 1);
    chk("b2b_f2_frame", cap_frame, 24'h000001);
    chk("b2b_f2_edges", cap_edges, 24);
    cnt_a = 0;
    for (int i = 0; i < 250; i++) begin
      if (!cs0) cnt_a++;
      @(negedge clk_in);
    end
    chk("b2b_no_third", cnt_a, 0);

    // Request pulsed mid-frame is ignored
    addr_in = 4'hA; data_in = 16'h5AC3; data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    capture(4, 10, 1'b0);
    chk("mid_timeout", cap_timeout, 1'b0);
    chk("mid_frame", cap_frame, 24'h0A5AC3);
    chk("mid_edges", cap_edges, 24);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 250; i++) begin
      if (!cs0) cnt_a++;
      if (done0) cnt_b++;
      @(negedge clk_in);
    end
    chk("mid_no_second", cnt_a, 0);
    chk("mid_no_done", cnt_b, 0);

    // Reset after the 12th rising SCLK edge
    addr_in = 4'h9; data_in = 16'h1357; data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    edges = 0; n = 0; prev = 1'b0;
    while (edges < 12 && n < 500) begin
      @(negedge clk_in);
      if (sclk0 && !prev) edges++;
      prev = sclk0;
      n++;
    end
    chk("rst_mid_edges", edges, 12);
    reset_in = 1'b1;
    @(negedge clk_in);
    chk("rst_mid_cs", cs0, 1'b1);
    chk("rst_mid_sclk", sclk0, 1'b0);
    chk("rst_mid_mosi", mosi0, 1'b0);
    chk("rst_mid_ready", ready0, 1'b1);
    reset_in = 1'b0;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      if (done0) cnt_b++;
      @(negedge clk_in);
    end
    chk("rst_mid_no_done", cnt_b, 0);
    addr_in = 4'h2; data_in = 16'h0BEE; data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    capture(4, -1, 1'b0);
    chk("post_rst_timeout", cap_timeout, 1'b0);
    chk("post_rst_frame", cap_frame, 24'h020BEE);
    chk("post_rst_edges", cap_edges, 24);
    chk("post_rst_cs_low", cap_low, 196);
    repeat (10) @(negedge clk_in);

    // CLK_DIV=2 instance
    sel = 1'b1;
    addr_in = 4'h5; data_in = 16'h8001; data_valid2 = 1'b1;
    @(negedge clk_in);
    data_valid2 = 1'b0;
    capture(2, -1, 1'b0);
    chk("div2_timeout", cap_timeout, 1'b0);
    chk("div2_frame", cap_frame, 24'h058001);
    chk("div2_edges", cap_edges, 24);
    chk("div2_cs_low", cap_low, 98);
    chk("div2_halfper", cap_hp_bad, 0);
    chk("div2_done_cnt", cap_done_cnt, 1);
    sel = 1'b0;
    repeat (10) @(negedge clk_in);

    // Loopback through a bench-side decoder
    addr_in = 4'h7; data_in = 16'hC0DE; data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    capture(4, -1, 1'b0);
    chk("loop_timeout", cap_timeout, 1'b0);
    chk("loop_pad", cap_frame[23:20], 4'h0);
    chk("loop_addr", cap_frame[19:16], 4'h7);
    chk("loop_data", cap_frame[15:0], 16'hC0DE);
    chk("loop_valid_pulses", cap_done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/spi_reg_writer.md
Name: spi_reg_writer

Overview:
- SPI initiator that turns parallel register-write requests (4-bit address, 16-bit data) into single SPI transactions.
- The frames are the ones the tone engine's spi_slave and spi_decoder accept.
- Used as an on-chip/bench controller to program the sample counter voices over the same 3-wire bus (CS, MOSI, SCLK).
- Write-only: no MISO path.

Parameters:
- CLK_DIV, 4: clk_in cycles per SCLK half-period. Legal range 2..255. Drives the 8-bit divider counter.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- addr_in  input  4  target register address.
- data_in  input  16  register write data.
- data_valid_in  input  1  write request; accepted on any cycle where data_valid_in=1 and ready_out=1.
- ready_out  output  1  high when idle and able to accept a request.
- done_out  output  1  one-cycle pulse on the cycle CS deasserts at end of frame.
- spi_cs_out  output  1  chip select, active low.
- spi_mosi_out  output  1  serial data, MSB first.
- spi_sclk_out  output  1  serial clock, SPI mode 0 (idle low, sampled on rising edge).

Behaviour:
- Frame format (fixed): 24 bits = {4'b0000, addr[3:0], data[15:8], data[7:0]}, sent MSB first as three bytes within one CS-low window.
- Reset (sync, priority over everything):
  - Next edge: spi_cs_out=1, spi_sclk_out=0, spi_mosi_out=0, done_out=0, ready_out=1, state=IDLE.
  - Counters and shift register cleared.
  - Any in-progress frame is abandoned; CS rises on that edge with no trailing SCLK edge.
- States: IDLE, SCK_LOW, SCK_HIGH, HOLD, GAP.
- IDLE:
  - cs=1, sclk=0, mosi=0, ready_out=1.
  - On an accept edge: latch the 24-bit frame into the shift register, bit counter=23, divider=0, go to SCK_LOW, ready_out=0.
- SCK_LOW:
  - cs=0, sclk=0, mosi=shift[23].
  - Stays CLK_DIV cycles, then goes to SCK_HIGH.
  - The first SCK_LOW acts as CS setup time: mosi is valid from the first CS-low cycle.
- SCK_HIGH:
  - cs=0, sclk=1, mosi unchanged.
  - Stays CLK_DIV cycles.
  - On leaving: if bit counter=0 go to HOLD; otherwise shift left by 1, decrement the counter, and go to SCK_LOW.
  - mosi therefore changes only on the falling-edge cycle.
- HOLD: cs=0, sclk=0, mosi=0; lasts CLK_DIV cycles, then go to GAP with cs=1 and done_out=1 for exactly that first GAP cycle.
- GAP: cs=1, sclk=0, mosi=0; lasts CLK_DIV cycles, then go to IDLE.
- Timing, with the accept edge at T:
  - CS is low from T+1 for exactly 49*CLK_DIV cycles.
  - 24 rising SCLK edges, each CLK_DIV cycles after the corresponding MOSI update.
  - ready_out returns high at T+1+50*CLK_DIV.
  - At CLK_DIV=4: CS low for 196 cycles; next accept possible 201 cycles after the previous one.
- data_valid_in while ready_out=0 is ignored. There is no queue, and the request is not latched.
- addr_in and data_in are sampled only on the accept edge; changes afterwards do not affect the frame in flight.
- All outputs are registered, with no combinational path from input to output.
- Glitch-free outputs: each SPI output toggles at most once per state transition.
- A request held high continuously produces back-to-back frames separated by CLK_DIV+1 CS-high cycles (GAP plus the IDLE accept cycle).

Test Plan:
- Reset, then addr=3, data=0xA55A, CLK_DIV=4:
  - MOSI sampled on SCLK rising edges = 0x03A55A (24 bits).
  - Exactly 24 rising edges.
  - CS low for 196 cycles.
  - done_out pulses once as CS rises.
- Hold data_valid_in=1 with addr=0xF, data=0xFFFF, then addr=0x0, data=0x0001:
  - Two frames, 0x0FFFFF then 0x000001.
  - CS high for 5 cycles between them.
  - ready_out high for exactly 1 cycle between frames.
- Pulse data_valid_in (addr=1, data=0x1234) at bit 10 of a frame in flight:
  - The current frame completes unchanged.
  - No second frame is produced.
- Assert reset_in after the 12th rising SCLK edge:
  - Next edge: CS=1, SCLK=0, MOSI=0, ready_out=1.
  - No done_out pulse.
  - A following request (addr=2, data=0x0BEE) sends a clean 0x020BEE.
- CLK_DIV=2, addr=5, data=0x8001:
  - Every SCLK half-period is 2 cycles.
  - CS low for 98 cycles.
  - Bits decode to 0x058001.
- Loopback into the tone engine (spi_slave + spi_decoder), addr=7, data=0xC0DE:
  - decoder_addr_out=7 and decoder_data_out=0xC0DE, with a single decoder_data_valid_out pulse.
